// File: rtl/nor_bus_ctrl.sv
// Wishbone-to-parallel-NOR bridge: sequences single accesses and JEDEC command
// sets (program / sector erase / chip erase), then polls RY/BY# with a timeout.
module nor_bus_ctrl #(
    parameter int ADDRBITS     = 26,
    parameter int DATABITS     = 16,
    parameter int T_ACC        = 6,
    parameter int T_WP         = 3,
    parameter int T_HOLD       = 2,
    parameter int BUSY_TO_BITS = 24
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [DATABITS-1:0] wb_dat_i,
    output logic [DATABITS-1:0] wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_stall_o,
    output logic [ADDRBITS-1:0] nor_addr_o,
    output logic [DATABITS-1:0] nor_dq_o,
    input  logic [DATABITS-1:0] nor_dq_i,
    output logic                nor_dq_oe_o,
    output logic                nor_ce_n_o,
    output logic                nor_oe_n_o,
    output logic                nor_we_n_o,
    input  logic                nor_ryby_i
);

    localparam logic [5:0] CYC_READ         = 6'd0;
    localparam logic [5:0] CYC_WRITE        = 6'd1;
    localparam logic [5:0] CYC_RESET        = 6'd2;
    localparam logic [5:0] CYC_PROGRAM      = 6'd3;
    localparam logic [5:0] CYC_ERASE_SECTOR = 6'd4;
    localparam logic [5:0] CYC_ERASE_CHIP   = 6'd5;

    localparam int TMAX = (T_ACC > T_WP) ? ((T_ACC > T_HOLD) ? T_ACC : T_HOLD)
                                         : ((T_WP > T_HOLD) ? T_WP : T_HOLD);
    localparam int PW   = $clog2(TMAX + 1);

    localparam logic [ADDRBITS-1:0]     A_555     = ADDRBITS'(12'h555);
    localparam logic [ADDRBITS-1:0]     A_2AA     = ADDRBITS'(12'h2AA);
    // Timeout fires on the edge where the poll counter becomes all-ones.
    localparam logic [BUSY_TO_BITS-1:0] POLL_LAST = ~BUSY_TO_BITS'(1);
    localparam logic [BUSY_TO_BITS-1:0] POLL_MIN  = BUSY_TO_BITS'(4);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_POLL, S_RESP} state_t;

    function automatic logic [DATABITS-1:0] bval(input logic [7:0] b);
        return DATABITS'(b);
    endfunction

    function automatic logic [ADDRBITS-1:0] step_addr(input logic [5:0] c, input logic [2:0] s,
                                                      input logic [ADDRBITS-1:0] a);
        logic [ADDRBITS-1:0] r;
        r = a;
        case (c)
            CYC_RESET: r = '0;
            CYC_PROGRAM:
                if (s == 3'd0 || s == 3'd2) r = A_555;
                else if (s == 3'd1)         r = A_2AA;
            CYC_ERASE_SECTOR, CYC_ERASE_CHIP:
                if (s == 3'd1 || s == 3'd4)              r = A_2AA;
                else if (s != 3'd5 || c == CYC_ERASE_CHIP) r = A_555;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [DATABITS-1:0] step_dat(input logic [5:0] c, input logic [2:0] s,
                                                     input logic [DATABITS-1:0] d);
        logic [DATABITS-1:0] r;
        r = '0;
        case (c)
            CYC_WRITE: r = d;
            CYC_RESET: r = bval(8'hF0);
            CYC_PROGRAM:
                case (s)
                    3'd0:    r = bval(8'hAA);
                    3'd1:    r = bval(8'h55);
                    3'd2:    r = bval(8'hA0);
                    default: r = d;
                endcase
            CYC_ERASE_SECTOR, CYC_ERASE_CHIP:
                case (s)
                    3'd0, 3'd3: r = bval(8'hAA);
                    3'd1, 3'd4: r = bval(8'h55);
                    3'd2:       r = bval(8'h80);
                    default:    r = (c == CYC_ERASE_CHIP) ? bval(8'h10) : bval(8'h30);
                endcase
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] last_step(input logic [5:0] c);
        case (c)
            CYC_PROGRAM:                      return 3'd3;
            CYC_ERASE_SECTOR, CYC_ERASE_CHIP: return 3'd5;
            default:                          return 3'd0;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              step_q, step_d;
    logic [PW-1:0]           ph_q, ph_d;
    logic [BUSY_TO_BITS-1:0] poll_q, poll_d;
    logic [5:0]              cmd_q, cmd_d;
    logic [ADDRBITS-1:0]     adr_q, adr_d, addr_q, addr_d;
    logic [DATABITS-1:0]     dat_q, dat_d, dq_q, dq_d, rdat_q, rdat_d;
    logic                    err_q, err_d, abort_q, abort_d;
    logic                    sync1_q, sync2_q;
    logic                    is_rd, in_acc, needs_poll;
    logic [5:0]              code;
    logic                    unused_ok;

    assign code       = wb_adr_i[31:26];
    assign is_rd      = (cmd_q == CYC_READ);
    assign needs_poll = (cmd_q == CYC_PROGRAM) || (cmd_q == CYC_ERASE_SECTOR) ||
                        (cmd_q == CYC_ERASE_CHIP);
    assign unused_ok  = ^{wb_we_i, wb_adr_i};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ph_d    = ph_q;
        poll_d  = poll_q;
        cmd_d   = cmd_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        // A master that walks away mid-sequence still gets a complete flash op, but no reply.
        abort_d = abort_q | ((state_q != S_IDLE) & ~wb_cyc_i);
        case (state_q)
            S_IDLE:
                if (wb_cyc_i && wb_stb_i) begin
                    cmd_d   = code;
                    adr_d   = wb_adr_i[ADDRBITS-1:0];
                    dat_d   = wb_dat_i;
                    step_d  = 3'd0;
                    abort_d = 1'b0;
                    if (code <= CYC_ERASE_CHIP) begin
                        state_d = S_SETUP;
                        err_d   = 1'b0;
                        addr_d  = step_addr(code, 3'd0, wb_adr_i[ADDRBITS-1:0]);
                        dq_d    = step_dat(code, 3'd0, wb_dat_i);
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end
                end
            S_SETUP: begin
                state_d = S_STROBE;
                ph_d    = is_rd ? PW'(T_ACC - 1) : PW'(T_WP - 1);
            end
            S_STROBE:
                if (ph_q == '0) begin
                    state_d = S_HOLD;
                    ph_d    = PW'(T_HOLD - 1);
                    if (is_rd) rdat_d = nor_dq_i;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            S_HOLD:
                if (ph_q != '0) begin
                    ph_d = ph_q - 1'b1;
                end else if (step_q != last_step(cmd_q)) begin
                    state_d = S_SETUP;
                    step_d  = step_q + 3'd1;
                    addr_d  = step_addr(cmd_q, step_q + 3'd1, adr_q);
                    dq_d    = step_dat(cmd_q, step_q + 3'd1, dat_q);
                end else if (needs_poll) begin
                    state_d = S_POLL;
                    poll_d  = '0;
                end else begin
                    state_d = S_RESP;
                end
            S_POLL: begin
                poll_d = poll_q + 1'b1;
                if (poll_q >= POLL_MIN && sync2_q) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                end else if (poll_q == POLL_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            ph_q    <= '0;
            poll_q  <= '0;
            cmd_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ph_q    <= ph_d;
            poll_q  <= poll_d;
            cmd_q   <= cmd_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            sync1_q <= nor_ryby_i;
            sync2_q <= sync1_q;
        end
    end

    assign in_acc      = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign nor_ce_n_o  = ~in_acc;
    assign nor_oe_n_o  = ~((state_q == S_STROBE) && is_rd);
    assign nor_we_n_o  = ~((state_q == S_STROBE) && !is_rd);
    assign nor_dq_oe_o = in_acc && !is_rd;
    assign nor_addr_o  = addr_q;
    assign nor_dq_o    = dq_q;
    assign wb_dat_o    = rdat_q;
    assign wb_stall_o  = (state_q != S_IDLE);
    assign wb_ack_o    = (state_q == S_RESP) && !err_q && !abort_q;
    assign wb_err_o    = (state_q == S_RESP) && err_q && !abort_q;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Bench for nor_bus_ctrl: table vectors, hand-built corner sequences and random
// commands checked against a bus-level model of the expected NOR access list.
module tb_nor_bus_ctrl;
    localparam int AB = 26, DB = 16, TACC = 6, TWP = 3, THOLD = 2, BTB = 8;

    logic          clk_i = 1'b0;
    logic          reset_i, wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]   wb_adr_i;
    logic [DB-1:0] wb_dat_i, wb_dat_o, nor_dq_o, nor_dq_i;
    logic          wb_ack_o, wb_err_o, wb_stall_o;
    logic [AB-1:0] nor_addr_o;
    logic          nor_dq_oe_o, nor_ce_n_o, nor_oe_n_o, nor_we_n_o, nor_ryby_i;

    always #5 clk_i = ~clk_i;

    nor_bus_ctrl #(.ADDRBITS(AB), .DATABITS(DB), .T_ACC(TACC), .T_WP(TWP),
                   .T_HOLD(THOLD), .BUSY_TO_BITS(BTB)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
        .nor_addr_o(nor_addr_o), .nor_dq_o(nor_dq_o), .nor_dq_i(nor_dq_i),
        .nor_dq_oe_o(nor_dq_oe_o), .nor_ce_n_o(nor_ce_n_o), .nor_oe_n_o(nor_oe_n_o),
        .nor_we_n_o(nor_we_n_o), .nor_ryby_i(nor_ryby_i));

    typedef struct {
        logic [AB-1:0] addr;
        logic [DB-1:0] dat;
        bit            we;
        int            str_len;
        bit            stable;
        bit            oe_ok;
    } acc_t;

    typedef struct {
        logic [5:0]    code;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        logic [DB-1:0] dq;
        int            ack_c;
        int            err_c;
        logic [DB-1:0] rdat;
    } vec_t;

    acc_t exp_q[$], got_q[$];
    int   n_pass = 0, n_tot = 0;
    int   ce_tot, bad_strobe;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic void push_exp(input logic [AB-1:0] a, input logic [DB-1:0] d, input bit we);
        exp_q.push_back('{addr: a, dat: d, we: we, str_len: we ? TWP : TACC, stable: 1'b1, oe_ok: 1'b1});
    endfunction

    // Expected access list and response timing, cycle 0 = accept cycle.
    task automatic model(input logic [5:0] code, input logic [AB-1:0] a, input logic [DB-1:0] d,
                         input int ryby_low, input bit dropped,
                         output int e_ack, output int e_err, output int e_end, output int e_ce);
        bit known = 1, poll = 0;
        int t, k, resp;
        bit is_err;
        exp_q.delete();
        case (code)
            6'd0: push_exp(a, '0, 0);
            6'd1: push_exp(a, d, 1);
            6'd2: push_exp('0, 16'hF0, 1);
            6'd3: begin
                push_exp(26'h555, 16'hAA, 1); push_exp(26'h2AA, 16'h55, 1);
                push_exp(26'h555, 16'hA0, 1); push_exp(a, d, 1); poll = 1;
            end
            6'd4, 6'd5: begin
                push_exp(26'h555, 16'hAA, 1); push_exp(26'h2AA, 16'h55, 1);
                push_exp(26'h555, 16'h80, 1); push_exp(26'h555, 16'hAA, 1);
                push_exp(26'h2AA, 16'h55, 1);
                if (code == 6'd4) push_exp(a, 16'h30, 1); else push_exp(26'h555, 16'h10, 1);
                poll = 1;
            end
            default: known = 0;
        endcase
        e_ce = 0;
        foreach (exp_q[i]) e_ce += 1 + exp_q[i].str_len + THOLD;
        t = 1 + e_ce;
        is_err = 0;
        if (!known) begin
            resp = 1; is_err = 1;
        end else if (!poll) begin
            resp = t;
        end else begin
            // Synchronised RY/BY# lags the pin by two cycles; first four poll cycles ignore it.
            k = ryby_low + 2 - t;
            if (k < 4) k = 4;
            if (k <= (1 << BTB) - 2) resp = t + k + 1;
            else begin resp = t + (1 << BTB) - 1; is_err = 1; end
        end
        e_end = resp + 1;
        e_ack = (dropped || is_err) ? -1 : resp;
        e_err = (dropped || !is_err) ? -1 : resp;
    endtask

    task automatic run_txn(input logic [5:0] code, input logic [AB-1:0] a, input logic [DB-1:0] d,
                           input logic [DB-1:0] dq, input int ryby_low, input int drop_after,
                           output int ack_c, output int err_c, output int end_c);
        acc_t cur;
        int   mon = 0, h = 0;
        bit   s_ce, s_oe, s_we, strobe, p_ce = 0, p_oe_drv = 0;
        logic [AB-1:0] p_addr = '0;
        logic [DB-1:0] p_dq = '0, raw_dq = '0;
        cur = '{addr: '0, dat: '0, we: 0, str_len: 0, stable: 1, oe_ok: 1};
        got_q.delete();
        ack_c = -1; err_c = -1; end_c = -1; ce_tot = 0; bad_strobe = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = (code != 6'd0);
        wb_adr_i = {code, a}; wb_dat_i = d; nor_dq_i = ~dq;
        nor_ryby_i = (ryby_low == 0);
        for (int n = 1; n <= 1200 && end_c < 0; n++) begin
            @(posedge clk_i); #1;
            wb_stb_i = 0;
            if (n >= ryby_low) nor_ryby_i = 1;
            s_ce = !nor_ce_n_o; s_oe = !nor_oe_n_o; s_we = !nor_we_n_o;
            strobe = s_oe || s_we;
            ce_tot += int'(s_ce);
            if (!s_ce && (strobe || nor_dq_oe_o)) bad_strobe++;
            if (mon == 1 && strobe) begin
                cur.str_len++;
                if (nor_addr_o != cur.addr || nor_dq_o != raw_dq || s_we != cur.we ||
                    nor_dq_oe_o != cur.we) cur.stable = 0;
                if (s_oe && s_we) cur.oe_ok = 0;
            end else if (mon != 0) begin
                mon = 2;
                if (!s_ce || nor_addr_o != cur.addr || nor_dq_o != raw_dq ||
                    nor_dq_oe_o != cur.we) cur.stable = 0;
                h++;
                if (h == THOLD) begin
                    if (!cur.we) cur.dat = '0;
                    got_q.push_back(cur);
                    mon = 0;
                end
            end else if (strobe) begin
                mon = 1; h = 0;
                raw_dq = nor_dq_o;
                cur = '{addr: nor_addr_o, dat: nor_dq_o, we: s_we, str_len: 1, stable: 1,
                        oe_ok: (s_oe != s_we)};
                if (!p_ce || p_addr != nor_addr_o || p_dq != nor_dq_o || p_oe_drv != nor_dq_oe_o ||
                    nor_dq_oe_o != s_we) cur.stable = 0;
            end
            // Valid read data only during the final strobe cycle, to pin the capture point.
            nor_dq_i = (mon == 1 && s_oe && cur.str_len == TACC) ? dq : ~dq;
            p_ce = s_ce; p_addr = nor_addr_o; p_dq = nor_dq_o; p_oe_drv = nor_dq_oe_o;
            if (wb_ack_o && ack_c < 0) ack_c = n;
            if (wb_err_o && err_c < 0) err_c = n;
            if (wb_ack_o || wb_err_o) wb_cyc_i = 0;
            if (!wb_stall_o) end_c = n;
            if (drop_after >= 0 && got_q.size() == drop_after) wb_cyc_i = 0;
        end
        wb_cyc_i = 0; nor_ryby_i = 1;
        chk("txn_completed", longint'(end_c >= 0), 1);
    endtask

    task automatic check_txn(input string nm, input logic [5:0] code, input logic [AB-1:0] a,
                             input logic [DB-1:0] d, input logic [DB-1:0] dq, input int ryby_low,
                             input int drop_after, output int ack_c, output int err_c);
        int e_ack, e_err, e_end, e_ce, end_c, nmin;
        model(code, a, d, ryby_low, drop_after >= 0, e_ack, e_err, e_end, e_ce);
        run_txn(code, a, d, dq, ryby_low, drop_after, ack_c, err_c, end_c);
        chk({nm, "_nacc"}, got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("%s_a%0d_addr", nm, i), got_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s_a%0d_dat", nm, i), got_q[i].dat, exp_q[i].dat);
            chk($sformatf("%s_a%0d_we", nm, i), got_q[i].we, exp_q[i].we);
            chk($sformatf("%s_a%0d_strlen", nm, i), got_q[i].str_len, exp_q[i].str_len);
            chk($sformatf("%s_a%0d_stable", nm, i), got_q[i].stable, 1);
            chk($sformatf("%s_a%0d_strobe_excl", nm, i), got_q[i].oe_ok, 1);
        end
        chk({nm, "_ce_cycles"}, ce_tot, e_ce);
        chk({nm, "_strobe_outside_ce"}, bad_strobe, 0);
        chk({nm, "_ack_cycle"}, ack_c, e_ack);
        chk({nm, "_err_cycle"}, err_c, e_err);
        chk({nm, "_idle_cycle"}, end_c, e_end);
    endtask

    vec_t vt[7];
    int   ack_c, err_c;

    initial begin
        logic [DB-1:0] last_rdat;
        int stray;
        reset_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
        nor_dq_i = '0; nor_ryby_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ce_n", nor_ce_n_o, 1);
        chk("rst_oe_n", nor_oe_n_o, 1);
        chk("rst_we_n", nor_we_n_o, 1);
        chk("rst_outs", {nor_dq_oe_o, wb_ack_o, wb_err_o, wb_stall_o}, 0);
        chk("rst_addr_dq", {nor_addr_o, nor_dq_o}, 0);
        chk("rst_wb_dat", wb_dat_o, 0);
        reset_i = 0;
        @(posedge clk_i); #1;

        vt[0] = '{6'd0,  26'h123,     16'h0000, 16'hBEEF, 10, -1, 16'hBEEF};
        vt[1] = '{6'd1,  26'h3FFFFFF, 16'hA5A5, 16'h0F0F,  7, -1, 16'hBEEF};
        vt[2] = '{6'd2,  26'h2AA,     16'h1111, 16'h2222,  7, -1, 16'hBEEF};
        vt[3] = '{6'h3F, 26'h1,       16'h3333, 16'h4444, -1,  1, 16'hBEEF};
        vt[4] = '{6'd6,  26'h555,     16'h5555, 16'h6666, -1,  1, 16'hBEEF};
        vt[5] = '{6'd0,  26'h0,       16'h7777, 16'h0000, 10, -1, 16'h0000};
        vt[6] = '{6'd0,  26'h3FFFFFF, 16'h8888, 16'hFFFF, 10, -1, 16'hFFFF};
        foreach (vt[i]) begin
            check_txn($sformatf("vec%0d", i), vt[i].code, vt[i].a, vt[i].d, vt[i].dq, 0, -1, ack_c, err_c);
            chk($sformatf("vec%0d_tbl_ack", i), ack_c, vt[i].ack_c);
            chk($sformatf("vec%0d_tbl_err", i), err_c, vt[i].err_c);
            chk($sformatf("vec%0d_rdat", i), wb_dat_o, vt[i].rdat);
        end

        check_txn("program", 6'd3, 26'h40, 16'h1234, 16'h0, 50, -1, ack_c, err_c);
        chk("program_ack_after_ryby", ack_c, 53);
        check_txn("erase_to", 6'd4, 26'h1000, 16'h0, 16'h0, 100000, -1, ack_c, err_c);
        chk("erase_to_err_at", err_c, 1 + 36 + 255);
        check_txn("chip_drop", 6'd5, 26'h0, 16'h0, 16'h0, 60, 2, ack_c, err_c);
        check_txn("read_after_drop", 6'd0, 26'h55, 16'h0, 16'h1357, 0, -1, ack_c, err_c);
        chk("read_after_drop_rdat", wb_dat_o, 16'h1357);

        // Reset in the middle of a read strobe.
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = {6'd0, 26'h77}; nor_dq_i = 16'h4321;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk_i); #1;
            wb_stb_i = 0;
        end
        chk("rstmid_pre_oe_n", nor_oe_n_o, 0);
        reset_i = 1;
        @(posedge clk_i); #1;
        chk("rstmid_ce_n", nor_ce_n_o, 1);
        chk("rstmid_oe_n", nor_oe_n_o, 1);
        chk("rstmid_stall", wb_stall_o, 0);
        chk("rstmid_ack_err", {wb_ack_o, wb_err_o}, 0);
        chk("rstmid_wb_dat", wb_dat_o, 0);
        reset_i = 0; wb_cyc_i = 0;
        stray = 0;
        repeat (12) begin
            @(posedge clk_i); #1;
            if (wb_ack_o || wb_err_o || !nor_ce_n_o) stray++;
        end
        chk("rstmid_no_resp", stray, 0);

        last_rdat = '0;
        for (int it = 0; it < 25; it++) begin
            logic [5:0]    code;
            logic [AB-1:0] a;
            logic [DB-1:0] d, dq;
            int            r, ryl;
            r    = $urandom_range(0, 7);
            code = (r < 6) ? 6'(r) : 6'($urandom_range(6, 63));
            a    = AB'($urandom);
            d    = DB'($urandom);
            dq   = DB'($urandom);
            ryl  = (code >= 6'd3 && code <= 6'd5) ? $urandom_range(0, 340) : 0;
            check_txn($sformatf("rnd%0d", it), code, a, d, dq, ryl, -1, ack_c, err_c);
            if (code == 6'd0) last_rdat = dq;
            chk($sformatf("rnd%0d_rdat", it), wb_dat_o, last_rdat);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
